// File: rtl/mem_bus_responder_pkg.sv
// Shared address map and read-select encoding for the CPU memory bus responder.
package mem_bus_responder_pkg;

    localparam logic [17:0] IO_BASE   = 18'h30000;
    localparam logic [17:0] ADDR_UART = 18'h30000;
    localparam logic [17:0] ADDR_CLK  = 18'h30004;
    localparam logic [17:0] RAM_LIMIT = 18'h20000;

    // rd_sel | meaning of cpu_dout in the cycle after the address
    // NONE   | previous cycle was a write; io byte is 0
    // RAM    | pass ram_rdata through
    // RXPOP  | byte popped from RX FIFO (0 if it was empty)
    // CNT0-3 | cycle counter byte 0 (live) or snapshot bytes 1-3
    // ZERO   | hole or unmapped IO read; io byte is 0
    typedef enum logic [2:0] {
        RD_NONE  = 3'd0,
        RD_RAM   = 3'd1,
        RD_RXPOP = 3'd2,
        RD_CNT0  = 3'd3,
        RD_CNT1  = 3'd4,
        RD_CNT2  = 3'd5,
        RD_CNT3  = 3'd6,
        RD_ZERO  = 3'd7
    } rd_sel_e;

    // Little-endian byte select out of a 32-bit word.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two circular byte FIFO with extra-bit pointers. A pop on an empty
// FIFO is a no-op; a push on a full FIFO is taken only when a pop frees a slot
// in the same cycle.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]          mem_q [DEPTH];
    logic                do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // Pointer advance for accepted pushes and pops.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, do_pop};
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Target side of the CPU byte-wide memory bus: RAM pass-through, UART FIFOs,
// cycle counter with coherent snapshot, and the sticky program-stop flag.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int RAM_AW         = 17,
    parameter int TXQ_DEPTH_LOG2 = 3,
    parameter int RXQ_DEPTH_LOG2 = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [31:0]       cpu_a,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              program_stop,
    output logic              tx_overflow
);
    logic [17:0] addr;
    logic [15:0] io_off;
    logic        hit_ram, hit_io, hit_uart, hit_cnt, hit_stop;
    logic        rd_en, wr_en;
    logic        unused_addr_hi;

    assign addr           = cpu_a[17:0];
    assign io_off         = addr[15:0];
    assign unused_addr_hi = ^cpu_a[31:18];

    assign hit_ram  = (addr < RAM_LIMIT);
    assign hit_io   = (addr[17:16] == IO_BASE[17:16]);
    assign hit_uart = hit_io & (io_off == ADDR_UART[15:0]);
    assign hit_cnt  = hit_io & (io_off[15:2] == ADDR_CLK[15:2]);
    assign hit_stop = hit_io & (io_off == ADDR_CLK[15:0]);

    assign rd_en = rdy_in & ~cpu_wr;
    assign wr_en = rdy_in & cpu_wr;

    // RAM is a straight pass-through; write enable is held off during reset.
    assign ram_a     = cpu_a[RAM_AW-1:0];
    assign ram_wdata = cpu_din;
    assign ram_we    = rst_in & wr_en & hit_ram;

    // TX FIFO: CPU pushes, UART pops. Zero bytes to the UART port are
    // filtered, but a stop write deliberately queues a 0x00 terminator.
    logic       tx_full, tx_empty, tx_pop, tx_req;
    logic [7:0] tx_din;

    assign tx_req   = wr_en & ((hit_uart & (cpu_din != 8'h00)) | hit_stop);
    assign tx_din   = hit_stop ? 8'h00 : cpu_din;
    assign tx_pop   = ~tx_empty & tx_ready;
    assign tx_valid = ~tx_empty;

    byte_fifo #(.DEPTH_LOG2(TXQ_DEPTH_LOG2)) u_tx_fifo (
        .clk_i  (clk_in),
        .rst_ni (rst_in),
        .push_i (tx_req),
        .din_i  (tx_din),
        .pop_i  (tx_pop),
        .dout_o (tx_data),
        .full_o (tx_full),
        .empty_o(tx_empty)
    );

    // RX FIFO: UART pushes, a CPU read of the UART port pops.
    logic       rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0] rx_head;

    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & ~rx_full;
    assign rx_pop   = rd_en & hit_uart & ~rx_empty;

    byte_fifo #(.DEPTH_LOG2(RXQ_DEPTH_LOG2)) u_rx_fifo (
        .clk_i  (clk_in),
        .rst_ni (rst_in),
        .push_i (rx_push),
        .din_i  (rx_data),
        .pop_i  (rx_pop),
        .dout_o (rx_head),
        .full_o (rx_full),
        .empty_o(rx_empty)
    );

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic        stop_q, stop_d;
    logic        ovf_q, ovf_d;
    rd_sel_e     rd_sel_q, rd_sel_d;
    logic [7:0]  io_byte_q, io_byte_d;

    // Next state: counter, snapshot, sticky flags and the read-select stage.
    always_comb begin
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        rd_sel_d  = rd_sel_q;
        io_byte_d = io_byte_q;
        stop_d    = stop_q | (wr_en & hit_stop);
        ovf_d     = ovf_q | (tx_req & tx_full & ~tx_pop);
        if (rdy_in) begin
            cnt_d     = cnt_q + 32'd1;
            rd_sel_d  = RD_NONE;
            io_byte_d = 8'h00;
            if (!cpu_wr) begin
                rd_sel_d = RD_ZERO;
                if (hit_ram) begin
                    rd_sel_d = RD_RAM;
                end else if (hit_uart) begin
                    rd_sel_d  = RD_RXPOP;
                    io_byte_d = rx_empty ? 8'h00 : rx_head;
                end else if (hit_cnt) begin
                    case (addr[1:0])
                        2'd0: begin
                            rd_sel_d  = RD_CNT0;
                            io_byte_d = cnt_q[7:0];
                            snap_d    = cnt_q;
                        end
                        2'd1: begin
                            rd_sel_d  = RD_CNT1;
                            io_byte_d = byte_of(snap_q, 2'd1);
                        end
                        2'd2: begin
                            rd_sel_d  = RD_CNT2;
                            io_byte_d = byte_of(snap_q, 2'd2);
                        end
                        2'd3: begin
                            rd_sel_d  = RD_CNT3;
                            io_byte_d = byte_of(snap_q, 2'd3);
                        end
                    endcase
                end
            end
        end
    end

    // State registers; reset drops any in-flight read.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt_q     <= '0;
            snap_q    <= '0;
            stop_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rd_sel_q  <= RD_NONE;
            io_byte_q <= 8'h00;
        end else begin
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            stop_q    <= stop_d;
            ovf_q     <= ovf_d;
            rd_sel_q  <= rd_sel_d;
            io_byte_q <= io_byte_d;
        end
    end

    assign cpu_dout     = (rd_sel_q == RD_RAM) ? ram_rdata : io_byte_q;
    assign program_stop = stop_q;
    assign tx_overflow  = ovf_q;

endmodule
